// File: rtl/wide_add_seq.sv
// Multi-byte add/subtract sequencer that time-shares an external 8-bit adder,
// processing one byte per clock from the low byte upward with a registered carry.
module wide_add_seq #(
  parameter int unsigned BYTES = 4
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               START,
  input  logic               SUB,
  input  logic [8*BYTES-1:0] OPA,
  input  logic [8*BYTES-1:0] OPB,
  output logic               BUSY,
  output logic               DONE,
  output logic [8*BYTES-1:0] RESULT,
  output logic               C_OUT,
  output logic               V_OUT,
  output logic               Z_OUT,
  output logic [7:0]         ADD_A,
  output logic [7:0]         ADD_B,
  output logic               ADD_CI,
  input  logic [7:0]         ADD_Y,
  input  logic               ADD_C,
  input  logic               ADD_V
);

  localparam int unsigned W  = 8 * BYTES;
  localparam int unsigned IW = $clog2(BYTES);
  localparam logic [IW-1:0] LAST = IW'(BYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [W-1:0]  opa_r;
  logic [W-1:0]  opb_r;
  logic          sub_r;
  logic [IW-1:0] idx;
  logic          cy_r;
  logic [W-1:0]  acc_r;
  logic [W-1:0]  acc_nx;
  logic          accept;
  logic          last;

  // FIN accepts a new request exactly like IDLE, giving back-to-back operation.
  assign accept = START && (state != RUN);
  assign last   = (state == RUN) && (idx == LAST);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (START) state_nx = RUN;
      RUN:     if (idx == LAST) state_nx = FIN;
      FIN:     state_nx = START ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    BUSY   = 1'b0;
    DONE   = 1'b0;
    ADD_A  = '0;
    ADD_B  = '0;
    ADD_CI = 1'b0;
    case (state)
      RUN: begin
        BUSY   = 1'b1;
        ADD_A  = opa_r[8*idx +: 8];
        ADD_B  = opb_r[8*idx +: 8] ^ {8{sub_r}};
        ADD_CI = (idx == '0) ? sub_r : cy_r;
      end
      FIN:     DONE = 1'b1;
      default: ;
    endcase
  end

  // Accumulator with the current byte merged in, so the final edge can
  // publish the complete result and its zero flag in the same cycle.
  always_comb begin
    acc_nx = acc_r;
    acc_nx[8*idx +: 8] = ADD_Y;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      opa_r  <= '0;
      opb_r  <= '0;
      sub_r  <= 1'b0;
      idx    <= '0;
      cy_r   <= 1'b0;
      acc_r  <= '0;
      RESULT <= '0;
      C_OUT  <= 1'b0;
      V_OUT  <= 1'b0;
      Z_OUT  <= 1'b0;
    end else if (accept) begin
      opa_r <= OPA;
      opb_r <= OPB;
      sub_r <= SUB;
      idx   <= '0;
    end else if (state == RUN) begin
      acc_r <= acc_nx;
      cy_r  <= ADD_C;
      idx   <= last ? '0 : idx + 1'b1;
      if (last) begin
        RESULT <= acc_nx;
        C_OUT  <= ADD_C;
        V_OUT  <= ADD_V;
        Z_OUT  <= (acc_nx == '0);
      end
    end
  end

endmodule

// File: tb/tb_wide_add_seq.sv
// Randomised self-checking bench for wide_add_seq with an 8-bit adder model
// and a full-width arithmetic reference.
module tb_wide_add_seq;

  localparam int unsigned BYTES = 4;
  localparam int unsigned W = 8 * BYTES;

  logic         CLK;
  logic         RST_N;
  logic         START;
  logic         SUB;
  logic [W-1:0] OPA;
  logic [W-1:0] OPB;
  logic         BUSY;
  logic         DONE;
  logic [W-1:0] RESULT;
  logic         C_OUT;
  logic         V_OUT;
  logic         Z_OUT;
  logic [7:0]   ADD_A;
  logic [7:0]   ADD_B;
  logic         ADD_CI;
  logic [7:0]   ADD_Y;
  logic         ADD_C;
  logic         ADD_V;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [W-1:0] last_res = '0;

  wide_add_seq #(.BYTES(BYTES)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .SUB(SUB), .OPA(OPA), .OPB(OPB),
    .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT), .C_OUT(C_OUT), .V_OUT(V_OUT),
    .Z_OUT(Z_OUT), .ADD_A(ADD_A), .ADD_B(ADD_B), .ADD_CI(ADD_CI),
    .ADD_Y(ADD_Y), .ADD_C(ADD_C), .ADD_V(ADD_V)
  );

  // External shared 8-bit adder.
  always_comb begin
    {ADD_C, ADD_Y} = {1'b0, ADD_A} + {1'b0, ADD_B} + {8'd0, ADD_CI};
    ADD_V = (ADD_A[7] == ADD_B[7]) && (ADD_Y[7] != ADD_A[7]);
  end

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_quiet_ports();
    check("add_a_idle", ADD_A, 0);
    check("add_b_idle", ADD_B, 0);
    check("add_ci_idle", ADD_CI, 0);
  endtask

  // Call at a negedge where the DUT is in IDLE or FIN.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    START = 1'b1;
    OPA   = a;
    OPB   = b;
    SUB   = s;
  endtask

  // Walks the RUN cycles of an accepted operation and checks the FIN cycle.
  // Returns at the FIN negedge with START deasserted.
  task automatic finish_op(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic s, input bit noise);
    logic [W-1:0] bx;
    logic [W:0]   sum;
    logic [W:0]   part;
    logic [W:0]   mask;
    logic [W-1:0] res;
    logic         exp_v;
    bx  = s ? ~b : b;
    sum = {1'b0, a} + {1'b0, bx} + {{W{1'b0}}, s};
    res = sum[W-1:0];
    exp_v = s ? ((a[W-1] != b[W-1]) && (res[W-1] != a[W-1]))
              : ((a[W-1] == b[W-1]) && (res[W-1] != a[W-1]));
    for (int unsigned k = 0; k < BYTES; k++) begin
      @(negedge CLK);
      mask = ({{W{1'b0}}, 1'b1} << (8 * k)) - 1'b1;
      part = (({1'b0, a} & mask) + ({1'b0, bx} & mask) + {{W{1'b0}}, s}) >> (8 * k);
      check("busy_run", BUSY, 1);
      check("done_run", DONE, 0);
      check("add_a", ADD_A, a[8*k +: 8]);
      check("add_b", ADD_B, bx[8*k +: 8]);
      check("add_ci", ADD_CI, (k == 0) ? s : part[0]);
      check("result_hold", RESULT, last_res);
      if (noise) begin
        START = 1'b1;
        OPA   = $urandom;
        OPB   = $urandom;
        SUB   = 1'($urandom_range(0, 1));
      end else begin
        START = 1'b0;
      end
    end
    @(negedge CLK);
    START = 1'b0;
    check("done_fin", DONE, 1);
    check("busy_fin", BUSY, 0);
    check("result", RESULT, res);
    check("c_out", C_OUT, sum[W]);
    check("v_out", V_OUT, exp_v);
    check("z_out", Z_OUT, res == '0);
    check_quiet_ports();
    last_res = res;
  endtask

  task automatic idle_check();
    @(negedge CLK);
    check("busy_idle", BUSY, 0);
    check("done_idle", DONE, 0);
    check("result_idle", RESULT, last_res);
    check_quiet_ports();
  endtask

  task automatic run_single(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic s, input bit noise);
    issue(a, b, s);
    finish_op(a, b, s, noise);
    idle_check();
  endtask

  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    START = 1'b0;
    SUB   = 1'b0;
    OPA   = '0;
    OPB   = '0;
    RST_N = 1'b1;
    #1 RST_N = 1'b0;
    #2;
    check("rst_busy", BUSY, 0);
    check("rst_done", DONE, 0);
    check("rst_result", RESULT, 0);
    check("rst_flags", {C_OUT, V_OUT, Z_OUT}, 0);
    check_quiet_ports();
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    idle_check();

    run_single(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
    check("plan_ff_plus_1", RESULT, 32'h0000_0100);
    run_single(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    check("plan_wrap_flags", {C_OUT, V_OUT, Z_OUT}, 3'b101);
    run_single(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    check("plan_ovf", {RESULT, C_OUT, V_OUT, Z_OUT}, {32'h8000_0000, 3'b010});
    run_single(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0);
    check("plan_sub_borrow", {RESULT, C_OUT, V_OUT}, {32'hFFFF_FFFE, 2'b00});
    run_single(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0);
    check("plan_sub_ovf", {RESULT, C_OUT, V_OUT}, {32'h7FFF_FFFF, 2'b11});

    // START re-asserted with other operands during RUN must be ignored.
    run_single(32'h1234_5678, 32'h0F0F_0F0F, 1'b0, 1'b1);

    // Back-to-back: START high in FIN is accepted with no idle cycle.
    issue(32'hDEAD_BEEF, 32'h0000_1111, 1'b1);
    finish_op(32'hDEAD_BEEF, 32'h0000_1111, 1'b1, 1'b0);
    issue(32'h0000_0001, 32'hFFFF_FFFF, 1'b0);
    finish_op(32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0);
    idle_check();

    // Asynchronous reset in the middle of RUN (idx = 2).
    run_single(32'hA5A5_A5A5, 32'h0101_0101, 1'b0, 1'b0);
    issue(32'h0102_0304, 32'h1111_1111, 1'b0);
    @(negedge CLK);
    START = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    check("mid_busy", BUSY, 1);
    #2 RST_N = 1'b0;
    #1;
    check("arst_busy", BUSY, 0);
    check("arst_done", DONE, 0);
    check("arst_result", RESULT, 0);
    check("arst_flags", {C_OUT, V_OUT, Z_OUT}, 0);
    check_quiet_ports();
    @(negedge CLK);
    RST_N = 1'b1;
    last_res = '0;
    for (int i = 0; i < 6; i++) idle_check();
    run_single(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0);

    // Randomised operations, some chained back-to-back, some with START noise.
    a = $urandom;
    b = $urandom;
    s = 1'($urandom_range(0, 1));
    issue(a, b, s);
    for (int i = 0; i < 40; i++) begin
      finish_op(a, b, s, 1'($urandom_range(0, 1)));
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      s = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 0) idle_check();
      issue(a, b, s);
    end
    finish_op(a, b, s, 1'b0);
    idle_check();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
